// File: rtl/bvh_unit.sv
// BVH traversal engine: walks a two-wide BVH from node memory for one ray,
// slab-testing both child boxes per node and reporting hit leaf primitive ranges.
module bvh_unit #(
    parameter int W       = 32,
    parameter int FRAC    = 16,
    parameter int NODE_W  = 8,
    parameter int PRIM_W  = 8,
    parameter int CNT_W   = 4,
    parameter int STACK_D = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              strobe,
    input  logic                              restart_strobe,
    input  logic [3*W-1:0]                    offset,
    input  logic [6*W-1:0]                    r,
    output logic [NODE_W-1:0]                 node_index,
    input  logic [2*(6*W+1+NODE_W)-1:0]       node,
    input  logic [2*(PRIM_W+CNT_W)-1:0]       leaf,
    output logic [2*PRIM_W-1:0]               start_prim,
    output logic [2*CNT_W-1:0]                num_prim,
    output logic                              valid,
    output logic                              finished
);

    localparam int CW   = 6*W + 1 + NODE_W;
    localparam int LW   = PRIM_W + CNT_W;
    localparam int SP_W = $clog2(STACK_D + 1);
    localparam int AW   = $clog2(STACK_D);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_D);

    typedef enum logic [1:0] {IDLE, FETCH, TEST, DONE} state_t;

    state_t              state, state_nxt;
    logic [6*W-1:0]      ray_q;
    logic [3*W-1:0]      off_q;
    logic [NODE_W-1:0]   stack [STACK_D];
    logic [SP_W-1:0]     sp;
    logic [SP_W-1:0]     sp_m1;
    logic [1:0]          hit, is_leaf, leaf_hit, int_hit;
    logic [NODE_W-1:0]   child_idx [2];
    logic                start, descend, push, pop, push_ok;
    logic [NODE_W-1:0]   desc_idx;

    // ((bound + offset - orig) * inv) >>> FRAC, full 2W product truncated to W
    function automatic logic signed [W-1:0] slab_t(input logic signed [W-1:0] bound,
                                                   input logic signed [W-1:0] off,
                                                   input logic signed [W-1:0] orig,
                                                   input logic signed [W-1:0] inv);
        logic signed [W-1:0]   d;
        logic signed [2*W-1:0] p, ps;
        d  = bound + off - orig;
        p  = {{W{d[W-1]}}, d} * {{W{inv[W-1]}}, inv};
        ps = p >>> FRAC;
        return ps[W-1:0];
    endfunction

    for (genvar c = 0; c < 2; c++) begin : g_child
        logic signed [W-1:0] t0, t1, tlo, thi, tnear, tfar;

        always_comb begin
            t0 = '0; t1 = '0; tlo = '0; thi = '0; tnear = '0; tfar = '0;
            for (int unsigned k = 0; k < 3; k++) begin
                t0  = slab_t(node[c*CW + k*W +: W], off_q[k*W +: W],
                             ray_q[k*W +: W], ray_q[(3+k)*W +: W]);
                t1  = slab_t(node[c*CW + (3+k)*W +: W], off_q[k*W +: W],
                             ray_q[k*W +: W], ray_q[(3+k)*W +: W]);
                tlo = (t0 < t1) ? t0 : t1;
                thi = (t0 < t1) ? t1 : t0;
                if (k == 0 || tlo > tnear) tnear = tlo;
                if (k == 0 || thi < tfar)  tfar  = thi;
            end
        end

        assign hit[c]       = (tnear <= tfar) && (tfar >= 0);
        assign is_leaf[c]   = node[c*CW + 6*W];
        assign child_idx[c] = node[c*CW + 6*W + 1 +: NODE_W];
    end

    assign leaf_hit = hit & is_leaf;
    assign int_hit  = hit & ~is_leaf;
    assign sp_m1    = sp - SP_W'(1);
    assign push_ok  = push && (sp != SP_FULL);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        descend   = 1'b0;
        desc_idx  = '0;
        push      = 1'b0;
        pop       = 1'b0;
        if (restart_strobe) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (strobe) begin
                        start     = 1'b1;
                        state_nxt = FETCH;
                    end
                end
                FETCH: state_nxt = TEST;
                TEST: begin
                    if (int_hit[0]) begin
                        descend   = 1'b1;
                        desc_idx  = child_idx[0];
                        push      = int_hit[1];
                        state_nxt = FETCH;
                    end else if (int_hit[1]) begin
                        descend   = 1'b1;
                        desc_idx  = child_idx[1];
                        state_nxt = FETCH;
                    end else if (sp != '0) begin
                        pop       = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = DONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ray_q      <= '0;
            off_q      <= '0;
            sp         <= '0;
            node_index <= '0;
            start_prim <= '0;
            num_prim   <= '0;
            valid      <= 1'b0;
            finished   <= 1'b0;
        end else begin
            valid      <= 1'b0;
            start_prim <= '0;
            num_prim   <= '0;
            if (restart_strobe) begin
                sp         <= '0;
                node_index <= '0;
                finished   <= 1'b0;
            end else begin
                if (start) begin
                    ray_q      <= r;
                    off_q      <= offset;
                    node_index <= '0;
                    sp         <= '0;
                    finished   <= 1'b0;
                end else if (state == DONE) begin
                    finished <= 1'b1;
                end
                if (state == TEST) begin
                    valid <= |leaf_hit;
                    for (int unsigned c = 0; c < 2; c++) begin
                        if (leaf_hit[c]) begin
                            start_prim[c*PRIM_W +: PRIM_W] <= leaf[c*LW +: PRIM_W];
                            num_prim[c*CNT_W +: CNT_W]     <= leaf[c*LW + PRIM_W +: CNT_W];
                        end
                    end
                    if (descend) begin
                        node_index <= desc_idx;
                    end else if (pop) begin
                        node_index <= stack[sp_m1[AW-1:0]];
                        sp         <= sp_m1;
                    end
                    if (push_ok) sp <= sp + SP_W'(1);
                end
            end
        end
    end

    // Stack storage needs no reset: emptiness is carried entirely by sp
    always_ff @(posedge clk) begin
        if (state == TEST && !restart_strobe && push_ok)
            stack[sp[AW-1:0]] <= child_idx[1];
    end

endmodule

// File: tb/tb_bvh_unit.sv
// Self-checking bench for bvh_unit: directed trees plus random trees/rays
// compared against a behavioural traversal model.
module tb_bvh_unit;

    localparam int W   = 32;
    localparam int CW  = 6*W + 1 + 8;
    localparam int ONE = 65536;
    localparam int BIG = 1 << 24;

    typedef struct packed {
        bit [2:0][31:0] mn;
        bit [2:0][31:0] mx;
        bit             lf;
        bit [7:0]       child;
        bit [7:0]       sp;
        bit [3:0]       np;
    } child_t;

    typedef struct packed {
        int       idx;
        bit [7:0] s0, s1;
        bit [3:0] n0, n1;
    } rep_t;

    logic            clk, resetn, strobe, restart_strobe;
    logic [3*W-1:0]  offset;
    logic [6*W-1:0]  r;
    logic [7:0]      node_index;
    logic [2*CW-1:0] node;
    logic [23:0]     leaf;
    logic [15:0]     start_prim;
    logic [7:0]      num_prim;
    logic            valid, finished;

    child_t tree [256][2];
    int     r_org[3], r_inv[3], r_off[3];
    rep_t   exp_q[$];
    int     errors = 0;
    int     checks = 0;
    int     inv_tab[6];

    bvh_unit #(.W(32), .FRAC(16), .NODE_W(8), .PRIM_W(8), .CNT_W(4), .STACK_D(16)) dut (
        .clk(clk), .resetn(resetn), .strobe(strobe), .restart_strobe(restart_strobe),
        .offset(offset), .r(r), .node_index(node_index), .node(node), .leaf(leaf),
        .start_prim(start_prim), .num_prim(num_prim), .valid(valid), .finished(finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*CW-1:0] pack_node(input logic [7:0] n);
        logic [2*CW-1:0] v;
        v = '0;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) begin
                v[c*CW + k*32 +: 32]     = tree[n][c].mn[k];
                v[c*CW + (3+k)*32 +: 32] = tree[n][c].mx[k];
            end
            v[c*CW + 6*32]         = tree[n][c].lf;
            v[c*CW + 6*32 + 1 +: 8] = tree[n][c].child;
        end
        return v;
    endfunction

    // Synchronous node memory
    always @(posedge clk) begin
        node <= pack_node(node_index);
        leaf <= {tree[node_index][1].np, tree[node_index][1].sp,
                 tree[node_index][0].np, tree[node_index][0].sp};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit model_hit(input child_t ch);
        int lo, hi, d0, d1, t0, t1, tl, th, tn, tf;
        tn = 0; tf = 0;
        for (int k = 0; k < 3; k++) begin
            lo = ch.mn[k] + r_off[k];
            hi = ch.mx[k] + r_off[k];
            d0 = lo - r_org[k];
            d1 = hi - r_org[k];
            t0 = int'((longint'(d0) * longint'(r_inv[k])) >>> 16);
            t1 = int'((longint'(d1) * longint'(r_inv[k])) >>> 16);
            tl = (t0 < t1) ? t0 : t1;
            th = (t0 < t1) ? t1 : t0;
            if (k == 0 || tl > tn) tn = tl;
            if (k == 0 || th < tf) tf = th;
        end
        return (tn <= tf) && (tf >= 0);
    endfunction

    // Depth-first traversal with an explicit LIFO; records reports per visit number
    task automatic model_run(output int nn);
        int   stk[$];
        int   cur;
        bit   h0, h1, ih0, ih1;
        rep_t rep;
        nn = 0; cur = 0;
        for (int it = 0; it < 64; it++) begin
            nn++;
            h0  = model_hit(tree[cur][0]);
            h1  = model_hit(tree[cur][1]);
            rep = '0;
            rep.idx = nn - 1;
            if (h0 && tree[cur][0].lf) begin rep.s0 = tree[cur][0].sp; rep.n0 = tree[cur][0].np; end
            if (h1 && tree[cur][1].lf) begin rep.s1 = tree[cur][1].sp; rep.n1 = tree[cur][1].np; end
            if ((h0 && tree[cur][0].lf) || (h1 && tree[cur][1].lf)) exp_q.push_back(rep);
            ih0 = h0 && !tree[cur][0].lf;
            ih1 = h1 && !tree[cur][1].lf;
            if (ih0) begin
                if (ih1 && stk.size() < 16) stk.push_back(int'(tree[cur][1].child));
                cur = int'(tree[cur][0].child);
            end else if (ih1) begin
                cur = int'(tree[cur][1].child);
            end else if (stk.size() > 0) begin
                cur = stk.pop_back();
            end else begin
                break;
            end
        end
    endtask

    task automatic clear_tree();
        for (int n = 0; n < 16; n++) begin
            tree[n][0] = '0;
            tree[n][1] = '0;
        end
    endtask

    task automatic mk_child(input int n, input int c, input int lo, input int hi,
                            input bit lf, input int ch, input int sp, input int np);
        for (int k = 0; k < 3; k++) begin
            tree[n][c].mn[k] = lo;
            tree[n][c].mx[k] = hi;
        end
        tree[n][c].lf    = lf;
        tree[n][c].child = 8'(ch);
        tree[n][c].sp    = 8'(sp);
        tree[n][c].np    = 4'(np);
    endtask

    task automatic set_ray(input int ox, input int oy, input int oz,
                           input int ix, input int iy, input int iz,
                           input int fx, input int fy, input int fz);
        r_org = '{ox, oy, oz};
        r_inv = '{ix, iy, iz};
        r_off = '{fx, fy, fz};
    endtask

    task automatic drive_ray();
        for (int k = 0; k < 3; k++) begin
            r[k*32 +: 32]     = r_org[k];
            r[(3+k)*32 +: 32] = r_inv[k];
            offset[k*32 +: 32] = r_off[k];
        end
    endtask

    task automatic scramble_ray();
        for (int k = 0; k < 6; k++) r[k*32 +: 32] = $urandom;
        for (int k = 0; k < 3; k++) offset[k*32 +: 32] = $urandom;
    endtask

    task automatic run_trav(input string tag);
        int   nn;
        rep_t rep;
        bit   expv;
        exp_q.delete();
        model_run(nn);
        @(negedge clk);
        drive_ray();
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        scramble_ray();
        for (int cyc = 1; cyc <= 2*nn + 3; cyc++) begin
            if (cyc > 1) @(negedge clk);
            expv = (exp_q.size() > 0) && (exp_q[0].idx*2 + 3 == cyc);
            check({tag, " valid"}, valid, expv);
            if (expv) begin
                rep = exp_q.pop_front();
                check({tag, " num_prim0"}, num_prim[3:0], rep.n0);
                check({tag, " num_prim1"}, num_prim[7:4], rep.n1);
                if (rep.n0 != 0) check({tag, " start_prim0"}, start_prim[7:0], rep.s0);
                if (rep.n1 != 0) check({tag, " start_prim1"}, start_prim[15:8], rep.s1);
            end
            check({tag, " finished"}, finished, cyc >= 2*nn + 2);
        end
        check({tag, " unreported"}, exp_q.size(), 0);
    endtask

    task automatic build_tree1();
        clear_tree();
        mk_child(0, 0, -ONE, ONE, 1'b1, 0, 0, 2);
        mk_child(0, 1, -ONE, ONE, 1'b1, 0, 4, 3);
    endtask

    task automatic build_tree3();
        clear_tree();
        mk_child(0, 0, -ONE, ONE, 1'b0, 1, 0, 0);
        mk_child(0, 1, -ONE, ONE, 1'b0, 2, 0, 0);
        mk_child(1, 0, -ONE, ONE, 1'b1, 0, 10, 1);
        mk_child(1, 1, -ONE, ONE, 1'b1, 0, 20, 2);
        mk_child(2, 0, -ONE, ONE, 1'b1, 0, 30, 3);
        mk_child(2, 1, -ONE, ONE, 1'b1, 0, 40, 4);
    endtask

    task automatic rand_tree();
        int nxt, lo;
        clear_tree();
        nxt = 1;
        for (int n = 0; n < 16 && n < nxt; n++) begin
            for (int c = 0; c < 2; c++) begin
                for (int k = 0; k < 3; k++) begin
                    lo = int'($urandom_range(0, 6)) - 4;
                    tree[n][c].mn[k] = lo * ONE;
                    tree[n][c].mx[k] = (lo + int'($urandom_range(0, 3))) * ONE;
                end
                if (nxt < 15 && $urandom_range(0, 1) == 1) begin
                    tree[n][c].lf    = 1'b0;
                    tree[n][c].child = 8'(nxt);
                    nxt++;
                end else begin
                    tree[n][c].lf = 1'b1;
                end
                tree[n][c].sp = 8'($urandom_range(0, 255));
                tree[n][c].np = 4'($urandom_range(1, 15));
            end
        end
        for (int k = 0; k < 3; k++) begin
            r_org[k] = (int'($urandom_range(0, 8)) - 4) * ONE;
            r_inv[k] = inv_tab[$urandom_range(0, 5)];
            r_off[k] = (int'($urandom_range(0, 2)) - 1) * ONE;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        inv_tab = '{ONE, -ONE, 2*ONE, ONE/2, -(ONE/2), BIG};
        resetn = 1'b0; strobe = 1'b0; restart_strobe = 1'b0;
        r = '0; offset = '0;
        repeat (2) @(negedge clk);
        check("reset valid", valid, 0);
        check("reset finished", finished, 0);
        check("reset node_index", node_index, 0);
        check("reset start_prim", start_prim, 0);
        check("reset num_prim", num_prim, 0);
        resetn = 1'b1;

        build_tree1();
        set_ray(0, 0, -5*ONE, BIG, BIG, ONE, 0, 0, 0);
        run_trav("root_hit");
        set_ray(10*ONE, 10*ONE, -5*ONE, BIG, BIG, ONE, 0, 0, 0);
        run_trav("root_miss");
        set_ray(0, 0, -5*ONE, BIG, BIG, ONE, 20*ONE, 0, 0);
        run_trav("offset_miss");
        set_ray(20*ONE, 0, -5*ONE, BIG, BIG, ONE, 20*ONE, 0, 0);
        run_trav("offset_hit");

        build_tree3();
        set_ray(0, 0, -5*ONE, BIG, BIG, ONE, 0, 0, 0);
        run_trav("three_level");

        // Restart during the TEST of node 1, with a simultaneous strobe
        @(negedge clk);
        drive_ray();
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        repeat (3) @(negedge clk);
        restart_strobe = 1'b1;
        strobe = 1'b1;
        @(negedge clk);
        restart_strobe = 1'b0;
        strobe = 1'b0;
        check("restart node_index", node_index, 0);
        check("restart num_prim", num_prim, 0);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            check("restart valid", valid, 0);
            check("restart finished", finished, 0);
        end
        set_ray(ONE/2, 0, -5*ONE, BIG, BIG, ONE, 0, 0, 0);
        run_trav("after_restart");

        // Asynchronous reset during the TEST of node 2
        @(negedge clk);
        drive_ray();
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset node_index", node_index, 2);
        resetn = 1'b0;
        #1;
        check("async valid", valid, 0);
        check("async finished", finished, 0);
        check("async node_index", node_index, 0);
        check("async start_prim", start_prim, 0);
        check("async num_prim", num_prim, 0);
        @(negedge clk);
        check("in_reset valid", valid, 0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_reset valid", valid, 0);
        check("post_reset finished", finished, 0);
        run_trav("after_reset");

        for (int t = 0; t < 25; t++) begin
            rand_tree();
            run_trav($sformatf("rand%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
